// File: rtl/moravec_window_stream.sv
// moravec_window_stream: streaming 3x3 Moravec corner scorer with thinning keep/clear; MORAVEC_EDGE_REPLICATE_EN selects edge replication over zero padding
module moravec_window_stream #(
    parameter int PIXEL_W = 8,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int THRESH  = 100,
    localparam int SCORE_W = 2*PIXEL_W+1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_converge,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] in_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIXEL_W-1:0] out_pixel,
    output logic               out_corner,
    output logic [SCORE_W-1:0] out_score,
    output logic               out_last
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 2);
    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [CW-1:0] COL_END  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FL_BEATS = FW'(IMG_W + 1);

    logic [1:0]           r_state;
    logic                 r_live, r_conv;
    logic [CW-1:0]        r_col, r_ccol, r_ccol0;
    logic [RW-1:0]        r_row, r_crow, r_crow0;
    logic [FW-1:0]        r_fcnt;
    logic [PIXEL_W-1:0]   r_lb1 [IMG_W];
    logic [PIXEL_W-1:0]   r_lb2 [IMG_W];
    logic [PIXEL_W-1:0]   r_win [3][3];
    logic                 r_v0, r_v1, r_last1, r_bord1;
    logic [PIXEL_W-1:0]   r_c1;
    logic [2*PIXEL_W-1:0] r_sq [8];

    logic                 w_stall, w_en, w_acc, w_fbeat, w_beat, w_emit, w_frame_end;
    logic                 w_top, w_bot, w_lft, w_rgt, w_flat, w_corner;
    logic [PIXEL_W-1:0]   w_pix, w_c;
    logic [PIXEL_W-1:0]   w_nb [3][3];
    logic [PIXEL_W-1:0]   w_n [8];
    logic [2*PIXEL_W-1:0] w_sq [8];
    logic [SCORE_W-1:0]   w_e [4];
    logic [SCORE_W-1:0]   w_m01, w_m23, w_min;

    assign w_stall     = out_valid && !out_ready;
    assign w_en        = !w_stall;
    assign in_ready    = r_live && w_en && (r_state != S_FLUSH);
    assign w_acc       = in_valid && in_ready;
    assign w_fbeat     = w_en && (r_state == S_FLUSH) && (r_fcnt < FL_BEATS);
    assign w_beat      = w_acc || w_fbeat;
    assign w_emit      = w_beat && ((r_state != S_FILL) || (r_row == RW'(1) && r_col == CW'(1)));
    assign w_frame_end = (r_state == S_FLUSH) && w_en && r_v1 && r_last1;
    assign w_pix       = w_acc ? in_pixel : '0;

    // Frame sequencing: FSM, input/flush/centre counters and the per-frame converge flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live  <= 1'b0;
            r_state <= S_FILL;
            r_conv  <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_ccol  <= '0;
            r_crow  <= '0;
            r_fcnt  <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_frame_end) begin
                r_state <= S_FILL;
                r_col   <= '0;
                r_row   <= '0;
                r_ccol  <= '0;
                r_crow  <= '0;
                r_fcnt  <= '0;
            end else begin
                if (w_acc && r_state == S_FILL && r_row == '0 && r_col == '0)
                    r_conv <= cfg_converge;
                if (w_acc && r_state == S_FILL && r_row == RW'(1) && r_col == CW'(1))
                    r_state <= S_RUN;
                if (w_acc && r_state == S_RUN && r_row == ROW_END && r_col == COL_END)
                    r_state <= S_FLUSH;
                if (w_beat) begin
                    r_col <= (r_col == COL_END) ? '0 : r_col + 1'b1;
                    if (r_col == COL_END)
                        r_row <= (r_row == ROW_END) ? '0 : r_row + 1'b1;
                end
                if (w_fbeat)
                    r_fcnt <= r_fcnt + 1'b1;
                if (w_emit) begin
                    r_ccol <= (r_ccol == COL_END) ? '0 : r_ccol + 1'b1;
                    if (r_ccol == COL_END)
                        r_crow <= (r_crow == ROW_END) ? '0 : r_crow + 1'b1;
                end
            end
        end
    end

    // Line buffers and 3x3 window advance once per beat; stale contents are masked at frame edges
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_lb1[r_col] <= w_pix;
            r_lb2[r_col] <= r_lb1[r_col];
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= r_lb2[r_col];
            r_win[1][2] <= r_lb1[r_col];
            r_win[2][2] <= w_pix;
        end
    end

    assign w_top = (r_crow0 == '0);
    assign w_bot = (r_crow0 == ROW_END);
    assign w_lft = (r_ccol0 == '0);
    assign w_rgt = (r_ccol0 == COL_END);

`ifdef MORAVEC_EDGE_REPLICATE_EN
    logic [1:0] w_ri [3];
    logic [1:0] w_ci [3];
    assign w_ri[0] = w_top ? 2'd1 : 2'd0;
    assign w_ri[1] = 2'd1;
    assign w_ri[2] = w_bot ? 2'd1 : 2'd2;
    assign w_ci[0] = w_lft ? 2'd1 : 2'd0;
    assign w_ci[1] = 2'd1;
    assign w_ci[2] = w_rgt ? 2'd1 : 2'd2;
`endif

    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_col
`ifdef MORAVEC_EDGE_REPLICATE_EN
            assign w_nb[i][j] = r_win[w_ri[i]][w_ci[j]];
`else
            assign w_nb[i][j] = ((i == 0 && w_top) || (i == 2 && w_bot) ||
                                 (j == 0 && w_lft) || (j == 2 && w_rgt)) ? '0 : r_win[i][j];
`endif
        end
    end

    // Opposite pairs: W/E, N/S, NW/SE, NE/SW
    assign w_c    = w_nb[1][1];
    assign w_n[0] = w_nb[1][0];
    assign w_n[1] = w_nb[1][2];
    assign w_n[2] = w_nb[0][1];
    assign w_n[3] = w_nb[2][1];
    assign w_n[4] = w_nb[0][0];
    assign w_n[5] = w_nb[2][2];
    assign w_n[6] = w_nb[0][2];
    assign w_n[7] = w_nb[2][0];
    assign w_flat = (w_n[0] == w_c) && (w_n[1] == w_c) && (w_n[2] == w_c) && (w_n[3] == w_c);

    for (genvar k = 0; k < 8; k++) begin : g_sq
        logic [PIXEL_W-1:0] w_d;
        assign w_d     = (w_c > w_n[k]) ? w_c - w_n[k] : w_n[k] - w_c;
        assign w_sq[k] = {{PIXEL_W{1'b0}}, w_d} * {{PIXEL_W{1'b0}}, w_d};
    end

    // S1 datapath: squared differences, centre and border flag
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_c1    <= w_c;
            r_bord1 <= !w_flat && (w_c != '0);
            for (int k = 0; k < 8; k++)
                r_sq[k] <= w_sq[k];
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_sum
        assign w_e[k] = {1'b0, r_sq[2*k]} + {1'b0, r_sq[2*k+1]};
    end

    assign w_m01    = (w_e[0] < w_e[1]) ? w_e[0] : w_e[1];
    assign w_m23    = (w_e[2] < w_e[3]) ? w_e[2] : w_e[3];
    assign w_min    = (w_m01 < w_m23) ? w_m01 : w_m23;
    assign w_corner = (w_min >= SCORE_W'(THRESH));

    // Valid/last tracking through S0-S1 and the S2 output registers; all of it freezes on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0       <= 1'b0;
            r_crow0    <= '0;
            r_ccol0    <= '0;
            r_v1       <= 1'b0;
            r_last1    <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_pixel  <= '0;
            out_corner <= 1'b0;
            out_score  <= '0;
        end else if (w_en) begin
            r_v0 <= w_emit;
            if (w_emit) begin
                r_crow0 <= r_crow;
                r_ccol0 <= r_ccol;
            end
            r_v1      <= r_v0;
            r_last1   <= r_v0 && w_bot && w_rgt;
            out_valid <= r_v1;
            out_last  <= r_v1 && r_last1;
            if (r_v1) begin
                out_pixel  <= (r_bord1 && !w_corner && !r_conv) ? '0 : r_c1;
                out_corner <= w_corner;
                out_score  <= w_min;
            end
        end
    end
endmodule

// File: tb/tb_moravec_window_stream.sv
// tb_moravec_window_stream: directed frames with expected results from a coordinate-based reference model
module tb_moravec_window_stream;
    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W*H;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_converge = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  in_pixel = 8'd0;
    logic        in_ready, out_valid, out_corner, out_last;
    logic [7:0]  out_pixel;
    logic [16:0] out_score;

    logic [7:0]  img [N];
    logic [7:0]  res_pix [N];
    logic [16:0] res_score [N];
    logic        res_corner [N];
    logic        res_last [N];
    logic [7:0]  ref_pix [N];
    logic [16:0] ref_score [N];
    int n_out, n_checks = 0, n_pass = 0, cyc = 0, acc9 = 0, first_cyc = -1;

    moravec_window_stream dut (
        .clk(clk), .rst(rst), .cfg_converge(cfg_converge),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_corner(out_corner), .out_score(out_score), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nb(int r, int c);
`ifdef MORAVEC_EDGE_REPLICATE_EN
        int rr = r < 0 ? 0 : (r > H-1 ? H-1 : r);
        int cc = c < 0 ? 0 : (c > W-1 ? W-1 : c);
        return int'(img[rr*W+cc]);
`else
        if (r < 0 || r >= H || c < 0 || c >= W) return 0;
        return int'(img[r*W+c]);
`endif
    endfunction

    function automatic int sqd(int a, int b);
        return (a-b)*(a-b);
    endfunction

    function automatic void model(input int r, input int c, input bit conv,
                                  output int pix, output int score, output bit corner);
        int v = nb(r, c);
        int e[4];
        bit border;
        e[0] = sqd(v, nb(r, c-1)) + sqd(v, nb(r, c+1));
        e[1] = sqd(v, nb(r-1, c)) + sqd(v, nb(r+1, c));
        e[2] = sqd(v, nb(r-1, c-1)) + sqd(v, nb(r+1, c+1));
        e[3] = sqd(v, nb(r-1, c+1)) + sqd(v, nb(r+1, c-1));
        score = e[0];
        for (int k = 1; k < 4; k++) if (e[k] < score) score = e[k];
        corner = score >= 100;
        border = v != 0 && (nb(r-1, c) != v || nb(r+1, c) != v || nb(r, c-1) != v || nb(r, c+1) != v);
        pix = (border && !corner && !conv) ? 0 : v;
    endfunction

    task automatic run_frame(input bit conv, input int stall_pct, input int gap_pct);
        int idx = 0, budget = 0;
        bit held = 0, acc, take;
        logic [7:0] h_pix;
        logic [16:0] h_score;
        logic h_corner, h_last;
        n_out = 0;
        first_cyc = -1;
        while (n_out < N && budget < 3000) begin
            @(negedge clk);
            budget++;
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_pixel !== h_pix || out_score !== h_score ||
                    out_corner !== h_corner || out_last !== h_last)
                    $display("FAIL stall_hold result %0d: got pix %0d score %0d, held pix %0d score %0d", n_out, out_pixel, out_score, h_pix, h_score);
                else n_pass++;
            end
            in_valid = (idx < N) && ($urandom_range(99) >= gap_pct);
            in_pixel = img[idx < N ? idx : N-1];
            cfg_converge = conv;
            out_ready = $urandom_range(99) >= stall_pct;
            #1;
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            held = out_valid && !out_ready;
            if (held) begin
                h_pix = out_pixel; h_score = out_score; h_corner = out_corner; h_last = out_last;
                n_checks++;
                if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", in_ready);
                else n_pass++;
            end
            if (idx == N && !(out_valid && out_last)) begin
                n_checks++;
                if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready);
                else n_pass++;
            end
            acc = in_valid && in_ready;
            take = out_valid && out_ready;
            if (take) begin
                res_pix[n_out] = out_pixel; res_score[n_out] = out_score;
                res_corner[n_out] = out_corner; res_last[n_out] = out_last;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (idx == W+1) acc9 = cyc;
                idx++;
            end
            if (take) n_out++;
        end
        n_checks++;
        if (n_out != N) $display("FAIL frame_timeout results got %0d want %0d", n_out, N);
        else n_pass++;
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input bit conv);
        int p, s;
        bit c;
        for (int i = 0; i < N; i++) begin
            model(i / W, i % W, conv, p, s, c);
            n_checks++;
            if (res_pix[i] !== 8'(p)) $display("FAIL %s pix[%0d] got %0d want %0d", tag, i, res_pix[i], p);
            else n_pass++;
            n_checks++;
            if (res_score[i] !== 17'(s)) $display("FAIL %s score[%0d] got %0d want %0d", tag, i, res_score[i], s);
            else n_pass++;
            n_checks++;
            if (res_corner[i] !== c) $display("FAIL %s corner[%0d] got %b want %b", tag, i, res_corner[i], c);
            else n_pass++;
            n_checks++;
            if (res_last[i] !== (i == N-1)) $display("FAIL %s last[%0d] got %b want %b", tag, i, res_last[i], i == N-1);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_pixel !== 8'd0) $display("FAIL reset_out_pixel got %0d want 0", out_pixel); else n_pass++;
        n_checks++; if (out_corner !== 1'b0) $display("FAIL reset_out_corner got %b want 0", out_corner); else n_pass++;
        n_checks++; if (out_score !== 17'd0) $display("FAIL reset_out_score got %0d want 0", out_score); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_flat();
        for (int i = 0; i < N; i++) img[i] = 8'd50;
        run_frame(1'b0, 0, 0);
        check_frame("flat", 1'b0);
        n_checks++;
        if (first_cyc - acc9 != 2) $display("FAIL latency got %0d want 2", first_cyc - acc9);
        else n_pass++;
`ifdef MORAVEC_EDGE_REPLICATE_EN
        n_checks++; if (res_score[0] !== 17'd0 || res_pix[0] !== 8'd50) $display("FAIL flat_corner00 score %0d pix %0d want 0/50", res_score[0], res_pix[0]); else n_pass++;
        n_checks++; if (res_pix[3] !== 8'd50) $display("FAIL flat_top_edge pix got %0d want 50", res_pix[3]); else n_pass++;
`else
        n_checks++; if (res_score[0] !== 17'd2500 || res_corner[0] !== 1'b1) $display("FAIL flat_corner00 score %0d corner %b want 2500/1", res_score[0], res_corner[0]); else n_pass++;
        n_checks++; if (res_pix[3] !== 8'd0) $display("FAIL flat_top_edge pix got %0d want 0", res_pix[3]); else n_pass++;
`endif
        n_checks++; if (res_score[27] !== 17'd0 || res_pix[27] !== 8'd50) $display("FAIL flat_interior score %0d pix %0d want 0/50", res_score[27], res_pix[27]); else n_pass++;
        run_frame(1'b1, 0, 0);
        check_frame("flat_conv", 1'b1);
        n_checks++; if (res_pix[3] !== 8'd50) $display("FAIL flat_conv_top_edge pix got %0d want 50", res_pix[3]); else n_pass++;
    endtask

    task automatic test_spot();
        for (int i = 0; i < N; i++) img[i] = 8'd0;
        img[4*W+4] = 8'd200;
        run_frame(1'b0, 0, 0);
        check_frame("spot", 1'b0);
        n_checks++; if (res_score[36] !== 17'd80000) $display("FAIL spot_score got %0d want 80000", res_score[36]); else n_pass++;
        n_checks++; if (res_corner[36] !== 1'b1 || res_pix[36] !== 8'd200) $display("FAIL spot_keep corner %b pix %0d want 1/200", res_corner[36], res_pix[36]); else n_pass++;
        n_checks++; if (res_pix[37] !== 8'd0 || res_score[37] !== 17'd0) $display("FAIL spot_neighbour pix %0d score %0d want 0/0", res_pix[37], res_score[37]); else n_pass++;
    endtask

    task automatic test_step();
        for (int i = 0; i < N; i++) img[i] = (i % W) >= 4 ? 8'd100 : 8'd0;
        run_frame(1'b0, 0, 0);
        check_frame("step", 1'b0);
        n_checks++; if (res_score[28] !== 17'd0 || res_pix[28] !== 8'd0) $display("FAIL step_clear score %0d pix %0d want 0/0", res_score[28], res_pix[28]); else n_pass++;
        run_frame(1'b1, 0, 0);
        check_frame("step_conv", 1'b1);
        n_checks++; if (res_pix[28] !== 8'd100 || res_corner[28] !== 1'b0) $display("FAIL step_keep pix %0d corner %b want 100/0", res_pix[28], res_corner[28]); else n_pass++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(255));
        run_frame(1'b0, 0, 0);
        check_frame("rand", 1'b0);
        for (int i = 0; i < N; i++) begin
            ref_pix[i] = res_pix[i];
            ref_score[i] = res_score[i];
        end
        run_frame(1'b0, 30, 20);
        check_frame("rand_stall", 1'b0);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (res_pix[i] !== ref_pix[i] || res_score[i] !== ref_score[i])
                $display("FAIL stall_vs_free[%0d] got %0d/%0d want %0d/%0d", i, res_pix[i], res_score[i], ref_pix[i], ref_score[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rst_mid();
        int fed = 0, budget = 0;
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(255));
        out_ready = 1'b1;
        while (fed < 20 && budget < 200) begin
            @(negedge clk);
            budget++;
            in_valid = 1'b1;
            in_pixel = img[fed];
            #1;
            if (in_ready) begin
                @(posedge clk);
                fed++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL mid_reset_in_ready got %b want 0", in_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(255));
        run_frame(1'b1, 0, 0);
        check_frame("after_reset", 1'b1);
        repeat (5) begin
            @(negedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b0) $display("FAIL extra_output out_valid got %b want 0", out_valid); else n_pass++;
        end
        n_checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_flat();
        test_spot();
        test_step();
        test_backpressure();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
